// File: rtl/accelerator_trainer_fnn_matrix_receiver.sv
// rtl/accelerator_trainer_fnn_matrix_receiver.sv - element-by-element matrix load receiver
// Requests each element with I/J strobes, buffers the operand and serves it through a registered read port.
module accelerator_trainer_fnn_matrix_receiver #(
  parameter int DATA_SIZE  = 64,
  parameter int MAX_I      = 8,
  parameter int MAX_J      = 8,
  parameter int INDEX_SIZE = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  output logic                  READY,
  output logic                  ERROR,
  input  logic [DATA_SIZE-1:0]  SIZE_I_IN,
  input  logic [DATA_SIZE-1:0]  SIZE_J_IN,
  output logic                  DATA_OUT_I_ENABLE,
  output logic                  DATA_OUT_J_ENABLE,
  input  logic                  DATA_IN_I_ENABLE,
  input  logic                  DATA_IN_J_ENABLE,
  input  logic [DATA_SIZE-1:0]  DATA_IN,
  input  logic [INDEX_SIZE-1:0] RD_ADDR_I,
  input  logic [INDEX_SIZE-1:0] RD_ADDR_J,
  output logic [DATA_SIZE-1:0]  RD_DATA
);

  localparam int IW = (MAX_I > 1) ? $clog2(MAX_I) : 1;
  localparam int JW = (MAX_J > 1) ? $clog2(MAX_J) : 1;

  typedef enum logic [1:0] {IDLE, REQUEST, WAIT, ENDER} state_t;

  state_t               state, state_next;
  logic [IW-1:0]        idx_i, last_i;
  logic [JW-1:0]        idx_j, last_j;
  logic [DATA_SIZE-1:0] mem [MAX_I][MAX_J];
  logic                 size_ok, accept, last_col, last_row, rd_in_range;

  // Range check at full input width so oversized values never alias into range
  assign size_ok = (SIZE_I_IN != '0) && (SIZE_I_IN <= DATA_SIZE'(MAX_I)) &&
                   (SIZE_J_IN != '0) && (SIZE_J_IN <= DATA_SIZE'(MAX_J));
  assign accept      = (state == WAIT) && DATA_IN_J_ENABLE;
  assign last_col    = (idx_j == last_j);
  assign last_row    = (idx_i == last_i);
  assign rd_in_range = (RD_ADDR_I < INDEX_SIZE'(MAX_I)) && (RD_ADDR_J < INDEX_SIZE'(MAX_J));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (START && size_ok) state_next = REQUEST;
      REQUEST: state_next = WAIT;
      WAIT:    if (DATA_IN_J_ENABLE) state_next = (last_col && last_row) ? ENDER : REQUEST;
      ENDER:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      READY             <= 1'b0;
      ERROR             <= 1'b0;
      DATA_OUT_I_ENABLE <= 1'b0;
      DATA_OUT_J_ENABLE <= 1'b0;
      idx_i             <= '0;
      idx_j             <= '0;
      last_i            <= '0;
      last_j            <= '0;
      RD_DATA           <= '0;
    end else begin
      // Strobes are flopped from the next state; a new row starts after IDLE or a last column
      DATA_OUT_J_ENABLE <= (state_next == REQUEST);
      DATA_OUT_I_ENABLE <= (state_next == REQUEST) && ((state == IDLE) || last_col);
      RD_DATA           <= rd_in_range ? mem[RD_ADDR_I[IW-1:0]][RD_ADDR_J[JW-1:0]] : '0;
      case (state)
        IDLE: begin
          if (START) begin
            if (size_ok) begin
              last_i <= IW'(SIZE_I_IN) - IW'(1);
              last_j <= JW'(SIZE_J_IN) - JW'(1);
              idx_i  <= '0;
              idx_j  <= '0;
              READY  <= 1'b0;
              ERROR  <= 1'b0;
            end else begin
              READY  <= 1'b1;
              ERROR  <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (DATA_IN_J_ENABLE) begin
            if (DATA_IN_I_ENABLE != (idx_j == '0)) ERROR <= 1'b1;
            if (!last_col) begin
              idx_j <= idx_j + JW'(1);
            end else if (!last_row) begin
              idx_i <= idx_i + IW'(1);
              idx_j <= '0;
            end
          end
        end
        ENDER:   READY <= 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) mem[idx_i][idx_j] <= DATA_IN;
  end

endmodule

// File: tb/tb_accelerator_trainer_fnn_matrix_receiver.sv
// tb/tb_accelerator_trainer_fnn_matrix_receiver.sv - scoreboard bench for the matrix receiver
module tb_accelerator_trainer_fnn_matrix_receiver;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic        READY, ERROR;
  logic [63:0] SIZE_I_IN = '0, SIZE_J_IN = '0;
  logic        DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE;
  logic        DATA_IN_I_ENABLE = 1'b0, DATA_IN_J_ENABLE = 1'b0;
  logic [63:0] DATA_IN = '0;
  logic [7:0]  RD_ADDR_I = '0, RD_ADDR_J = '0;
  logic [63:0] RD_DATA;

  accelerator_trainer_fnn_matrix_receiver dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY), .ERROR(ERROR),
    .SIZE_I_IN(SIZE_I_IN), .SIZE_J_IN(SIZE_J_IN),
    .DATA_OUT_I_ENABLE(DATA_OUT_I_ENABLE), .DATA_OUT_J_ENABLE(DATA_OUT_J_ENABLE),
    .DATA_IN_I_ENABLE(DATA_IN_I_ENABLE), .DATA_IN_J_ENABLE(DATA_IN_J_ENABLE),
    .DATA_IN(DATA_IN), .RD_ADDR_I(RD_ADDR_I), .RD_ADDR_J(RD_ADDR_J), .RD_DATA(RD_DATA)
  );

  always #5 CLK = ~CLK;

  typedef struct { bit err; int lat; } done_t;

  int          checks = 0, errors = 0;
  int          cyc = 0, start_cyc = 0;
  int          j_strobes = 0, i_strobes = 0;
  done_t       done_q[$];
  logic [63:0] rd_q[$];
  logic [63:0] ref_mem [8][8];
  logic        rd_req = 1'b0, rd_req_q = 1'b0, ready_q = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge CLK) begin
    cyc      <= cyc + 1;
    rd_req_q <= rd_req;
  end

  always @(negedge CLK) begin
    if (DATA_OUT_J_ENABLE) j_strobes++;
    if (DATA_OUT_I_ENABLE) i_strobes++;
  end

  // Monitor: pops expectations whenever a read result or a READY rise is presented
  always @(negedge CLK) begin
    logic [63:0] e;
    done_t       d;
    if (rd_req_q) begin
      if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
      else begin
        e = rd_q.pop_front();
        check("rd_data", RD_DATA, e);
      end
    end
    if (READY && !ready_q) begin
      if (done_q.size() == 0) check("ready_unexpected", 1, 0);
      else begin
        d = done_q.pop_front();
        check("done_error", ERROR, d.err);
        if (d.lat >= 0) check("done_latency", cyc - start_cyc, d.lat);
      end
    end
    ready_q = READY;
  end

  task automatic start_load(logic [63:0] si, logic [63:0] sj, bit exp_err, int lat, bit push);
    @(negedge CLK);
    SIZE_I_IN = si; SIZE_J_IN = sj; START = 1'b1;
    start_cyc = cyc + 1;
    if (push) done_q.push_back('{exp_err, lat});
    @(negedge CLK);
    START = 1'b0;
  endtask

  // Producer: answers each request after a random delay, optionally with a junk strobe in REQUEST
  task automatic produce(int si, int sj, int dmax, int miss_r, int miss_c,
                         bit junk, bit rd_same, bit seq, logic [63:0] base);
    logic [63:0] v;
    int n;
    for (int r = 0; r < si; r++) begin
      for (int c = 0; c < sj; c++) begin
        n = 0;
        while (!DATA_OUT_J_ENABLE && n < 64) begin @(negedge CLK); n++; end
        if (!DATA_OUT_J_ENABLE) begin check("req_timeout", 0, 1); return; end
        check("ready_early", READY, 0);
        if (junk && ($urandom_range(1) == 1)) begin
          DATA_IN_J_ENABLE = 1'b1; DATA_IN_I_ENABLE = (c == 0);
          DATA_IN = {32'hDEAD0000, $urandom};
        end
        @(negedge CLK);
        DATA_IN_J_ENABLE = 1'b0;
        repeat ($urandom_range(dmax)) @(negedge CLK);
        v = seq ? base + 64'(r * sj + c) : {$urandom, $urandom};
        DATA_IN = v; DATA_IN_J_ENABLE = 1'b1;
        DATA_IN_I_ENABLE = (c == 0) && !(r == miss_r && c == miss_c);
        if (rd_same && r == 0 && c == 0) begin
          RD_ADDR_I = 0; RD_ADDR_J = 0; rd_req = 1'b1;
          rd_q.push_back(ref_mem[0][0]);
        end
        ref_mem[r][c] = v;
        @(negedge CLK);
        DATA_IN_J_ENABLE = 1'b0; DATA_IN_I_ENABLE = 1'b0; rd_req = 1'b0;
      end
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!READY && n < 20) begin @(negedge CLK); n++; end
    if (!READY) check("ready_timeout", 0, 1);
  endtask

  task automatic read_exp(int i, int j, logic [63:0] exp);
    @(negedge CLK);
    RD_ADDR_I = 8'(i); RD_ADDR_J = 8'(j); rd_req = 1'b1;
    rd_q.push_back(exp);
    @(negedge CLK);
    rd_req = 1'b0;
  endtask

  task automatic read_cell(int i, int j);
    read_exp(i, j, ref_mem[i][j]);
  endtask

  task automatic pulse_reset();
    @(negedge CLK); RST = 1'b0;
    @(negedge CLK); RST = 1'b1;
  endtask

  int j0, i0;

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_ready", READY, 0);
    check("rst_error", ERROR, 0);
    check("rst_strobe_j", DATA_OUT_J_ENABLE, 0);
    check("rst_strobe_i", DATA_OUT_I_ENABLE, 0);
    check("rst_rd_data", RD_DATA, 0);
    RST = 1'b1;
    @(negedge CLK);

    // 2x3 load, 1-cycle producer, values 1..6
    j0 = j_strobes; i0 = i_strobes;
    start_load(2, 3, 1'b0, 13, 1'b1);
    produce(2, 3, 0, -1, -1, 1'b0, 1'b0, 1'b1, 64'd1);
    wait_ready();
    check("t1_j_strobes", j_strobes - j0, 6);
    check("t1_i_strobes", i_strobes - i0, 2);
    read_exp(1, 2, 64'd6);
    read_exp(0, 0, 64'd1);
    read_exp(1, 0, 64'd4);

    // Same shape, random delays and ignored strobes in REQUEST
    for (int rep = 0; rep < 3; rep++) begin
      j0 = j_strobes; i0 = i_strobes;
      start_load(2, 3, 1'b0, -1, 1'b1);
      produce(2, 3, 5, -1, -1, 1'b1, 1'b0, 1'b0, 64'd0);
      wait_ready();
      check("t2_j_strobes", j_strobes - j0, 6);
      check("t2_i_strobes", i_strobes - i0, 2);
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 3; c++) read_cell(r, c);
    end

    // Missing row marker on (1,0): sticky error, element still stored
    start_load(2, 2, 1'b1, -1, 1'b1);
    produce(2, 2, 2, 1, 0, 1'b0, 1'b0, 1'b0, 64'd0);
    wait_ready();
    repeat (3) begin
      @(negedge CLK);
      check("t3_error_sticky", ERROR, 1);
    end
    read_cell(1, 0);
    read_cell(1, 1);
    start_load(1, 2, 1'b0, -1, 1'b1);
    produce(1, 2, 1, -1, -1, 1'b0, 1'b0, 1'b0, 64'd0);
    wait_ready();

    // Out-of-range sizes, including one that only fits after truncation
    pulse_reset();
    j0 = j_strobes;
    start_load(0, 3, 1'b1, 0, 1'b1);
    repeat (3) @(negedge CLK);
    check("t4a_ready", READY, 1);
    check("t4a_error", ERROR, 1);
    pulse_reset();
    start_load(3, 9, 1'b1, 0, 1'b1);
    repeat (3) @(negedge CLK);
    check("t4b_error", ERROR, 1);
    pulse_reset();
    start_load(1, 64'h1_0000_0001, 1'b1, 0, 1'b1);
    repeat (3) @(negedge CLK);
    check("t4c_error", ERROR, 1);
    check("t4_no_strobes", j_strobes - j0, 0);
    read_cell(0, 0);
    read_cell(0, 1);

    // Reset in WAIT with an ignored second START
    pulse_reset();
    start_load(2, 3, 1'b0, -1, 1'b0);
    produce(1, 1, 0, -1, -1, 1'b0, 1'b0, 1'b0, 64'd0);
    SIZE_I_IN = 1; SIZE_J_IN = 1; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    check("t5_wait_no_strobe", DATA_OUT_J_ENABLE, 0);
    RST = 1'b0;
    @(negedge CLK);
    check("t5_rst_ready", READY, 0);
    check("t5_rst_strobe_j", DATA_OUT_J_ENABLE, 0);
    check("t5_rst_strobe_i", DATA_OUT_I_ENABLE, 0);
    RST = 1'b1;
    j0 = j_strobes;
    repeat (4) @(negedge CLK);
    check("t5_idle_no_strobes", j_strobes - j0, 0);
    check("t5_idle_ready", READY, 0);
    start_load(1, 1, 1'b0, 3, 1'b1);
    produce(1, 1, 0, -1, -1, 1'b0, 1'b0, 1'b1, 64'hAB);
    wait_ready();
    read_exp(0, 0, 64'hAB);

    // Out-of-range reads and read-during-write
    read_exp(8, 0, 64'd0);
    read_exp(0, 8, 64'd0);
    start_load(1, 1, 1'b0, -1, 1'b1);
    produce(1, 1, 0, -1, -1, 1'b0, 1'b1, 1'b0, 64'd0);
    wait_ready();
    read_cell(0, 0);

    repeat (3) @(negedge CLK);
    check("done_q_drained", done_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
